fsmc_sync_bridge: RTL and testbench
===================================

Name: fsmc_sync_bridge

Overview:
- Synchronous slave bridge between the STM32 FSMC multiplexed address/data bus (NE, NADV, NOE, NWE, AD[15:0], A[18:16]) and NCH on-chip register/buffer channels.
- All FSMC strobes are resampled into the CLK domain, and a single state machine runs each bus transaction.
- Decodes a tag field into channel strobes, returns registered read data, and flags transaction completion and misses.

Parameters:
- DW, 16: data/AD bus width.
- AHW, 3: number of high address pins (A16..A18); full address width AW = DW+AHW.
- TAG_W, 4: width of the decode tag at ADDR[AW-1 -: TAG_W].
- TAG, 4'hA: tag value that selects this bridge.
- NCH, 4: channel count, power of two, at least 2; CHW = log2(NCH).
- CH_LSB, 12: LSB of the channel-select field in ADDR.
- OFS_W, 12: width of the word-offset field ADDR[OFS_W-1:0].
- RD_LAT, 1: CLK cycles from RD_STB to RD_DATA valid, range 1..3.
- MISS_DATA, 16'hDEAD: value driven on reads that miss.
- TMO, 255: idle-after-address timeout, in CLK cycles.

Ports:
- CLK in 1: system clock, at least 4x the FSMC HCLK/divider strobe rate.
- RST in 1: synchronous, active-high reset.
- NE in 1: FSMC chip select, active low, asynchronous.
- NADV in 1: address valid, active low; address is latched on its rising edge.
- NOE in 1: read strobe, active low.
- NWE in 1: write strobe, active low.
- AD_IN in DW: multiplexed AD bus input.
- A_HI in AHW: high address pins.
- AD_OUT out DW: read data to the pad tristate.
- AD_OE out 1: pad output enable.
- OFS out OFS_W: latched word offset, shared by all channels.
- WR_DATA out DW: write data, valid during WR_STB.
- WR_STB out NCH: one-hot, single-cycle write pulse.
- RD_STB out NCH: one-hot, single-cycle read request.
- RD_DATA in NCH*DW: channel read data, channel k at [k*DW +: DW].
- DONE out 1: single-cycle pulse at the end of every completed transaction (hit or miss).
- MISS_CNT out 8: saturating count of missed or aborted transactions.

Behaviour:
- **Synchronisers:** NE, NADV, NOE, NWE each pass through 2 flops plus an edge-detect flop. All decisions use the synchronised signals. AD_IN and A_HI are sampled unsynchronised at the detected edge. The FSMC must be configured with ADDHLD and DATAST of at least 4 CLK so these buses are stable.
- **Reset:** all outputs 0, AD_OE=0, AD_OUT=0, MISS_CNT=0, FSM in IDLE, synchroniser flops set to 1 (bus inactive).
- **State IDLE:** on NADV rise with NE low, latch ADDR = {A_HI, AD_IN}; hit = (tag==TAG); ch = ADDR[CH_LSB +: CHW]; OFS <= ADDR[OFS_W-1:0]. Go to ADDR.
- **State ADDR:**
  - NWE fall -> WAIT_WR.
  - NOE fall -> RD_REQ.
  - If both fall in the same cycle, the write wins and the read is ignored.
  - NE rise, or TMO cycles with no strobe -> IDLE, MISS_CNT+1, no DONE.
  - A new NADV rise re-latches the address and stays in ADDR.
- **State WAIT_WR:** on NWE rise, capture WR_DATA <= AD_IN.
  - Hit: WR_STB[ch] =1 for 1 cycle.
  - Miss: no strobe, MISS_CNT+1.
  - DONE pulses in the same cycle. Go to IDLE.
- **State RD_REQ:**
  - Hit: RD_STB[ch] =1 for 1 cycle, then wait RD_LAT cycles, then AD_OUT <= RD_DATA[ch].
  - Miss: AD_OUT <= MISS_DATA on the next cycle and MISS_CNT+1.
  - Then AD_OE <= 1; go to RD_DRV.
- **State RD_DRV:** hold AD_OUT and AD_OE until NOE rise, then AD_OE <= 0 in that cycle, DONE pulses, go to IDLE.
- **Read latency:** NOE fall at pin to AD_OE high is 3 sync cycles + 1 + RD_LAT + 1 CLK. The FSMC DATAST must exceed this.
- **NE rise during WAIT_WR, RD_REQ or RD_DRV:** abort, AD_OE <= 0 next cycle, no WR_STB if not yet issued, MISS_CNT+1, IDLE.
- **AD_OE** is never high outside RD_DRV.
- **MISS_CNT** saturates at 255 and does not wrap.
- **RST mid-transaction:** everything returns to reset values on the next edge, and AD_OE drops within 1 cycle. The bus transaction in progress is discarded and the next NADV starts fresh.
- **Strobe outputs:** WR_STB and RD_STB are at most one-hot and never both active.

Test Plan:
- **Write hit:** NE=0, address 19'h52005 (tag A, ch 2, ofs 5), then NWE pulse with AD=16'h1234 -> WR_STB=4'b0100 for exactly 1 cycle, WR_DATA=16'h1234, OFS=12'h005, DONE pulse, MISS_CNT=0.
- **Read hit, RD_LAT=1:** channel 1 RD_DATA=16'hBEEF, address 19'h51010, NOE low 12 CLK -> RD_STB=4'b0010 once, AD_OE high with AD_OUT=16'hBEEF until 1 cycle after the synced NOE rise, DONE once.
- **Read miss:** address 19'h30000 -> no RD_STB, AD_OUT=16'hDEAD, AD_OE asserted, MISS_CNT=1.
- **Abort and timeout:**
  - NADV latched, then NE rises with no strobe -> IDLE, MISS_CNT+1, no DONE.
  - Separately, no strobe for 256 CLK -> timeout, MISS_CNT+1.
- **RST mid-read:** RST during RD_DRV -> AD_OE=0 on the next edge, all outputs zero; the following write to ch 0 completes normally.
- **Saturation and collision:**
  - 300 miss writes -> MISS_CNT=255.
  - NOE and NWE falling in the same synced cycle -> write path only, no RD_STB.

Source files
------------

// File: rtl/fsmc_sync_bridge.sv
// fsmc_sync_bridge: FSMC multiplexed-bus slave resampled into CLK, decoding a tag into NCH register channels
module fsmc_sync_bridge #(
    parameter int DW = 16,
    parameter int AHW = 3,
    parameter int TAG_W = 4,
    parameter logic [TAG_W-1:0] TAG = 4'hA,
    parameter int NCH = 4,
    parameter int CH_LSB = 12,
    parameter int OFS_W = 12,
    parameter int RD_LAT = 1,
    parameter logic [DW-1:0] MISS_DATA = 16'hDEAD,
    parameter int TMO = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              NE,
    input  logic              NADV,
    input  logic              NOE,
    input  logic              NWE,
    input  logic [DW-1:0]     AD_IN,
    input  logic [AHW-1:0]    A_HI,
    output logic [DW-1:0]     AD_OUT,
    output logic              AD_OE,
    output logic [OFS_W-1:0]  OFS,
    output logic [DW-1:0]     WR_DATA,
    output logic [NCH-1:0]    WR_STB,
    output logic [NCH-1:0]    RD_STB,
    input  logic [NCH*DW-1:0] RD_DATA,
    output logic              DONE,
    output logic [7:0]        MISS_CNT
);
    localparam int CHW = $clog2(NCH);
    localparam int CW = $clog2(TMO + 4);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT_WR, RD_REQ, RD_WAIT, RD_DRV} state_t;

    state_t state, state_nxt;
    logic [3:0] s1, s2, s3;
    logic [CW-1:0] cnt;
    logic hit;
    logic [CHW-1:0] ch;
    logic [DW-1:0] rd_words [NCH];
    logic latch, wr_go, rd_go, cap_rd, cap_miss, done_go, miss_go;

    for (genvar k = 0; k < NCH; k++) begin : g_rd
        assign rd_words[k] = RD_DATA[k*DW +: DW];
    end

    // strobe order in the sync chain: {NE, NADV, NOE, NWE}
    wire ne_low    = ~s2[3];
    wire ne_rise   = s2[3] & ~s3[3];
    wire nadv_rise = s2[2] & ~s3[2];
    wire noe_fall  = ~s2[1] & s3[1];
    wire noe_rise  = s2[1] & ~s3[1];
    wire nwe_fall  = ~s2[0] & s3[0];
    wire nwe_rise  = s2[0] & ~s3[0];

    always_comb begin
        state_nxt = state;
        latch = 1'b0;
        wr_go = 1'b0;
        rd_go = 1'b0;
        cap_rd = 1'b0;
        cap_miss = 1'b0;
        done_go = 1'b0;
        miss_go = 1'b0;
        if (state != IDLE && ne_rise) begin
            miss_go = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (nadv_rise && ne_low) begin
                    latch = 1'b1;
                    state_nxt = ADDR;
                end
                ADDR: begin
                    if (nadv_rise) latch = 1'b1;
                    else if (nwe_fall) state_nxt = WAIT_WR;
                    else if (noe_fall) state_nxt = RD_REQ;
                    else if (cnt == CW'(TMO - 1)) begin
                        miss_go = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                WAIT_WR: if (nwe_rise) begin
                    wr_go = hit;
                    miss_go = ~hit;
                    done_go = 1'b1;
                    state_nxt = IDLE;
                end
                RD_REQ: begin
                    rd_go = hit;
                    cap_miss = ~hit;
                    miss_go = ~hit;
                    state_nxt = hit ? RD_WAIT : RD_DRV;
                end
                RD_WAIT: if (cnt == CW'(RD_LAT)) begin
                    cap_rd = 1'b1;
                    state_nxt = RD_DRV;
                end
                RD_DRV: if (noe_rise) begin
                    done_go = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
            state <= IDLE;
            cnt <= '0;
            hit <= 1'b0;
            ch <= '0;
            OFS <= '0;
            WR_DATA <= '0;
            WR_STB <= '0;
            RD_STB <= '0;
            AD_OUT <= '0;
            AD_OE <= 1'b0;
            DONE <= 1'b0;
            MISS_CNT <= '0;
        end else begin
            s1 <= {NE, NADV, NOE, NWE};
            s2 <= s1;
            s3 <= s2;
            state <= state_nxt;
            cnt <= (latch || state_nxt != state) ? '0 : cnt + 1'b1;
            if (latch) begin
                hit <= {A_HI, AD_IN[DW-1 -: TAG_W-AHW]} == TAG;
                ch <= AD_IN[CH_LSB +: CHW];
                OFS <= AD_IN[OFS_W-1:0];
            end
            if (state == WAIT_WR && nwe_rise) WR_DATA <= AD_IN;
            WR_STB <= wr_go ? NCH'(1) << ch : '0;
            RD_STB <= rd_go ? NCH'(1) << ch : '0;
            if (cap_miss) AD_OUT <= MISS_DATA;
            else if (cap_rd) AD_OUT <= rd_words[ch];
            // output enable is exactly "in RD_DRV", so it can never leak into other states
            AD_OE <= state_nxt == RD_DRV;
            DONE <= done_go;
            if (miss_go && MISS_CNT != 8'hFF) MISS_CNT <= MISS_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_fsmc_sync_bridge.sv
// tb_fsmc_sync_bridge: pin-level FSMC transactions checked against a table of expected results and a scoreboard
module tb_fsmc_sync_bridge;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic NE = 1'b1, NADV = 1'b1, NOE = 1'b1, NWE = 1'b1;
    logic [15:0] AD_IN = '0;
    logic [2:0] A_HI = '0;
    logic [15:0] AD_OUT;
    logic AD_OE;
    logic [11:0] OFS;
    logic [15:0] WR_DATA;
    logic [3:0] WR_STB, RD_STB;
    logic [63:0] RD_DATA = {16'h3C3C, 16'h2A2A, 16'hBEEF, 16'h0F0F};
    logic DONE;
    logic [7:0] MISS_CNT;

    fsmc_sync_bridge dut (
        .CLK(CLK), .RST(RST), .NE(NE), .NADV(NADV), .NOE(NOE), .NWE(NWE),
        .AD_IN(AD_IN), .A_HI(A_HI), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .OFS(OFS),
        .WR_DATA(WR_DATA), .WR_STB(WR_STB), .RD_STB(RD_STB), .RD_DATA(RD_DATA),
        .DONE(DONE), .MISS_CNT(MISS_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit is_wr;
        logic [18:0] addr;
        logic [15:0] data;
        logic [3:0] stb;
        logic [11:0] ofs;
        bit hit;
    } vec_t;

    vec_t tv[9];
    vec_t sb[$];
    vec_t e;
    int n_cmp = 0, n_bad = 0, done_cnt = 0, exp_mc = 0, d0 = 0;
    logic [3:0] wr_acc = '0, rd_acc = '0;
    int wr_n = 0, rd_n = 0;
    logic [15:0] wd_seen = '0, ao_seen = '0;
    bit oe_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic addr_phase(input logic [18:0] a);
        NE = 1'b0;
        A_HI = a[18:16];
        AD_IN = a[15:0];
        NADV = 1'b0;
        cyc(4);
        NADV = 1'b1;
        cyc(5);
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [15:0] d);
        addr_phase(a);
        NWE = 1'b0;
        AD_IN = d;
        cyc(6);
        NWE = 1'b1;
        cyc(5);
        NE = 1'b1;
        cyc(4);
    endtask

    task automatic bus_read(input logic [18:0] a);
        addr_phase(a);
        NOE = 1'b0;
        cyc(12);
        NOE = 1'b1;
        cyc(5);
        NE = 1'b1;
        cyc(4);
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back(v);
        if (v.is_wr) bus_write(v.addr, v.data);
        else bus_read(v.addr);
        chk("sb_drained", sb.size(), 0);
        if (!v.hit && exp_mc < 255) exp_mc++;
        chk("miss_cnt", MISS_CNT, exp_mc);
    endtask

    task automatic clear_mon();
        wr_acc = '0;
        rd_acc = '0;
        wr_n = 0;
        rd_n = 0;
        oe_seen = 1'b0;
    endtask

    // observes DUT pulses between transactions and settles each one against the scoreboard on DONE
    always @(negedge CLK) begin
        if (RST) clear_mon();
        else begin
            if (WR_STB != 0 || RD_STB != 0) chk("strobe_onehot", $countones({WR_STB, RD_STB}), 1);
            if (WR_STB != 0) begin
                wr_acc |= WR_STB;
                wr_n++;
                wd_seen = WR_DATA;
            end
            if (RD_STB != 0) begin
                rd_acc |= RD_STB;
                rd_n++;
            end
            if (AD_OE) begin
                oe_seen = 1'b1;
                ao_seen = AD_OUT;
            end
            if (DONE) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got DONE with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if (e.is_wr) begin
                        chk("wr_stb", wr_acc, e.stb);
                        chk("wr_pulses", wr_n, e.hit ? 1 : 0);
                        chk("wr_no_rdstb", rd_acc, 0);
                        chk("wr_no_oe", oe_seen, 0);
                        if (e.hit) chk("wr_data", wd_seen, e.data);
                    end else begin
                        chk("rd_stb", rd_acc, e.stb);
                        chk("rd_pulses", rd_n, e.hit ? 1 : 0);
                        chk("rd_no_wrstb", wr_acc, 0);
                        chk("rd_oe", oe_seen, 1);
                        chk("rd_data", ao_seen, e.data);
                    end
                    chk("ofs", OFS, e.ofs);
                end
                clear_mon();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{1'b1, 19'h52005, 16'h1234, 4'b0100, 12'h005, 1'b1};
        tv[1] = '{1'b0, 19'h51010, 16'hBEEF, 4'b0010, 12'h010, 1'b1};
        tv[2] = '{1'b0, 19'h30000, 16'hDEAD, 4'b0000, 12'h000, 1'b0};
        tv[3] = '{1'b1, 19'h50ABC, 16'h5A5A, 4'b0001, 12'hABC, 1'b1};
        tv[4] = '{1'b0, 19'h53FFF, 16'h3C3C, 4'b1000, 12'hFFF, 1'b1};
        tv[5] = '{1'b1, 19'h13000, 16'h7777, 4'b0000, 12'h000, 1'b0};
        tv[6] = '{1'b0, 19'h58000, 16'hDEAD, 4'b0000, 12'h000, 1'b0};
        tv[7] = '{1'b0, 19'h52123, 16'h2A2A, 4'b0100, 12'h123, 1'b1};
        tv[8] = '{1'b0, 19'h50000, 16'h0F0F, 4'b0001, 12'h000, 1'b1};

        cyc(3);
        chk("rst_wr_stb", WR_STB, 0);
        chk("rst_rd_stb", RD_STB, 0);
        chk("rst_ad_oe", AD_OE, 0);
        chk("rst_ad_out", AD_OUT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_miss_cnt", MISS_CNT, 0);
        chk("rst_ofs", OFS, 0);
        chk("rst_wr_data", WR_DATA, 0);
        RST = 1'b0;
        cyc(3);

        for (int i = 0; i < 9; i++) run_vec(tv[i]);

        // address latched, then chip select drops away with no strobe
        d0 = done_cnt;
        addr_phase(19'h52005);
        NE = 1'b1;
        cyc(6);
        exp_mc++;
        chk("abort_miss_cnt", MISS_CNT, exp_mc);
        chk("abort_no_done", done_cnt, d0);

        addr_phase(19'h51010);
        cyc(240);
        chk("tmo_not_early", MISS_CNT, exp_mc);
        cyc(60);
        exp_mc++;
        chk("tmo_miss_cnt", MISS_CNT, exp_mc);
        NE = 1'b1;
        cyc(4);
        chk("tmo_ne_idle", MISS_CNT, exp_mc);
        chk("tmo_no_done", done_cnt, d0);

        // NOE and NWE fall together: the write path must win
        sb.push_back('{1'b1, 19'h52005, 16'h4321, 4'b0100, 12'h005, 1'b1});
        addr_phase(19'h52005);
        NOE = 1'b0;
        NWE = 1'b0;
        AD_IN = 16'h4321;
        cyc(6);
        NOE = 1'b1;
        NWE = 1'b1;
        cyc(5);
        NE = 1'b1;
        cyc(4);
        chk("coll_sb_drained", sb.size(), 0);
        chk("coll_miss_cnt", MISS_CNT, exp_mc);

        // reset while driving read data
        addr_phase(19'h51010);
        NOE = 1'b0;
        for (int i = 0; i < 40 && !AD_OE; i++) cyc(1);
        chk("rst_mid_oe_before", AD_OE, 1);
        chk("rst_mid_data_before", AD_OUT, 16'hBEEF);
        RST = 1'b1;
        cyc(1);
        chk("rst_mid_ad_oe", AD_OE, 0);
        chk("rst_mid_ad_out", AD_OUT, 0);
        chk("rst_mid_rd_stb", RD_STB, 0);
        chk("rst_mid_done", DONE, 0);
        chk("rst_mid_miss_cnt", MISS_CNT, 0);
        chk("rst_mid_ofs", OFS, 0);
        RST = 1'b0;
        NOE = 1'b1;
        cyc(3);
        NE = 1'b1;
        cyc(4);
        exp_mc = 0;
        run_vec(tv[3]);

        for (int i = 0; i < 300; i++) run_vec(tv[5]);
        chk("miss_saturated", MISS_CNT, 255);
        run_vec(tv[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
